// File: rtl/bus_capture_if.sv
// Result-bus capture port bundle: bus sampling side plus valid/ready drain and error flags.
// master = bus/consumer side (testbench or fabric), slave = bus_capture.
interface bus_capture_if #(
    parameter int WIDTH = 32,
    parameter int NDRV  = 4,
    parameter int DEPTH = 4
);
    localparam int SW = $clog2(NDRV);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] bus_data;
    logic [NDRV-1:0]  drv_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SW-1:0]    out_src;
    logic [CW-1:0]    count;
    logic             err_contention;
    logic             err_overflow;
    logic             err_clr;

    modport master (
        output bus_data, drv_en, out_ready, err_clr,
        input  out_valid, out_data, out_src, count, err_contention, err_overflow
    );

    modport slave (
        input  bus_data, drv_en, out_ready, err_clr,
        output out_valid, out_data, out_src, count, err_contention, err_overflow
    );
endinterface

// File: rtl/bus_capture.sv
// Captures the tri-state result bus when exactly one driver is enabled and queues {data, source} in a FIFO.
// Latency 1 cycle bus->out_valid; drains on valid/ready; a push into a full FIFO without a pop is dropped.
// Contention and dropped captures raise sticky flags that never stall capture or drain.
module bus_capture #(
    parameter int WIDTH = 32,
    parameter int NDRV  = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    bus_capture_if.slave  bif
);
    localparam int SW = $clog2(NDRV);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [SW-1:0]    mem_src  [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_q;

    logic          one_hot;
    logic          contention;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;
    logic [SW-1:0] src_idx;

    always_comb begin
        src_idx = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (bif.drv_en[i]) src_idx = SW'(i);
        end
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
        one_hot    = (bif.drv_en != '0) && ((bif.drv_en & (bif.drv_en - NDRV'(1))) == '0);
        contention = (bif.drv_en != '0) && !one_hot;
        full       = (count_q == CW'(DEPTH));
        pop        = bif.out_valid && bif.out_ready;
        accept     = one_hot && (!full || pop);
        drop       = one_hot && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr           <= '0;
            rptr           <= '0;
            count_q        <= '0;
            bif.err_contention <= 1'b0;
            bif.err_overflow   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_src[i]  <= '0;
            end
        end else begin
            if (accept) begin
                mem_data[wptr] <= bif.bus_data;
                mem_src[wptr]  <= src_idx;
                wptr           <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            if (accept && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !accept) count_q <= count_q - CW'(1);
            // A new error event in the same cycle as err_clr keeps the flag set.
            bif.err_contention <= contention | (bif.err_contention & ~bif.err_clr);
            bif.err_overflow   <= drop       | (bif.err_overflow   & ~bif.err_clr);
        end
    end

    assign bif.out_valid = (count_q != '0);
    assign bif.out_data  = mem_data[rptr];
    assign bif.out_src   = mem_src[rptr];
    assign bif.count     = count_q;
endmodule

// File: tb/tb_bus_capture.sv
// Bench for bus_capture: directed vector table, a set-wins sequence, then random traffic vs. a queue model.
module tb_bus_capture;
    localparam int WIDTH = 32;
    localparam int NDRV  = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_capture_if #(.WIDTH(WIDTH), .NDRV(NDRV), .DEPTH(DEPTH)) bif ();

    bus_capture #(.WIDTH(WIDTH), .NDRV(NDRV), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic [31:0] data;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  es;
        logic [2:0]  ecnt;
        logic        econ;
        logic        eovf;
        logic        dchk;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic r, input logic [3:0] en, input logic [31:0] data,
                        input logic rdy, input logic clr, input logic ev, input logic [31:0] ed,
                        input logic [1:0] es, input logic [2:0] ecnt, input logic econ,
                        input logic eovf, input logic dchk);
        vec_t v;
        v.rst = r; v.en = en; v.data = data; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.es = es; v.ecnt = ecnt; v.econ = econ; v.eovf = eovf; v.dchk = dchk;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, return at the following falling edge.
    task automatic step(input logic r, input logic [3:0] en, input logic [31:0] data,
                        input logic rdy, input logic clr);
        rst           = r;
        bif.drv_en    = en;
        bif.bus_data  = data;
        bif.out_ready = rdy;
        bif.err_clr   = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model state
    logic [31:0] mq_data[$];
    logic [1:0]  mq_src[$];
    logic        m_con;
    logic        m_ovf;

    task automatic model_cycle(input logic r, input logic [3:0] en, input logic [31:0] data,
                               input logic rdy, input logic clr);
        int  n;
        int  idx;
        logic do_pop, do_push, drop;
        if (r) begin
            mq_data.delete(); mq_src.delete();
            m_con = 1'b0; m_ovf = 1'b0;
            return;
        end
        n   = $countones(en);
        idx = 0;
        for (int i = 0; i < NDRV; i++) if (en[i]) idx = i;
        do_pop  = (mq_data.size() > 0) && rdy;
        do_push = (n == 1);
        drop    = do_push && (mq_data.size() == DEPTH) && !do_pop;
        if (do_pop) begin
            void'(mq_data.pop_front());
            void'(mq_src.pop_front());
        end
        if (do_push && !drop) begin
            mq_data.push_back(data);
            mq_src.push_back(2'(idx));
        end
        m_con = (n >= 2) || (m_con && !clr);
        m_ovf = drop || (m_ovf && !clr);
    endtask

    initial begin
        logic [31:0] xd;
        xd = 'x;
        bif.drv_en = '0; bif.bus_data = '0; bif.out_ready = 1'b0; bif.err_clr = 1'b0;

        // Directed table
        addv(1, 4'b0000, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 1);
        addv(0, 4'b0100, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 2, 1, 0, 0, 1);
        addv(0, 4'b0000, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            addv(0, 4'b0000, (i % 3 == 0) ? xd : (i[0] ? 32'hAAAAAAAA : 32'h55555555),
                 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        addv(0, 4'b0011, 32'h1, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        addv(0, 4'b0000, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        addv(0, 4'b0011, 32'h1, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0);
        addv(0, 4'b0000, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            addv(0, 4'b0010, 32'h10 + k, 0, 0, 1, 32'h10, 1, (k < 4) ? 3'(k + 1) : 3'd4,
                 0, (k == 4), 1);
        addv(0, 4'b0000, 32'h0,  0, 1, 1, 32'h10, 1, 4, 0, 0, 1);
        addv(0, 4'b0010, 32'h20, 1, 0, 1, 32'h11, 1, 4, 0, 0, 1);
        addv(0, 4'b0000, 32'h0,  1, 0, 1, 32'h12, 1, 3, 0, 0, 1);
        addv(0, 4'b0000, 32'h0,  1, 0, 1, 32'h13, 1, 2, 0, 0, 1);
        addv(0, 4'b0000, 32'h0,  1, 0, 1, 32'h20, 1, 1, 0, 0, 1);
        addv(0, 4'b0000, 32'h0,  1, 0, 0, 32'h0,  0, 0, 0, 0, 0);
        addv(0, 4'b0100, 32'h1,  0, 0, 1, 32'h1,  2, 1, 0, 0, 1);
        addv(0, 4'b0100, 32'h2,  0, 0, 1, 32'h1,  2, 2, 0, 0, 1);
        addv(1, 4'b0010, 32'h3,  0, 0, 0, 32'h0,  0, 0, 0, 0, 1);
        addv(0, 4'b1000, 32'hA5, 0, 0, 1, 32'hA5, 3, 1, 0, 0, 1);
        addv(0, 4'b0000, 32'h0,  1, 0, 0, 32'h0,  0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].en, vq[i].data, vq[i].rdy, vq[i].clr);
            chk($sformatf("v%0d.valid", i), 32'(bif.out_valid),      32'(vq[i].ev));
            chk($sformatf("v%0d.count", i), 32'(bif.count),          32'(vq[i].ecnt));
            chk($sformatf("v%0d.econ", i),  32'(bif.err_contention), 32'(vq[i].econ));
            chk($sformatf("v%0d.eovf", i),  32'(bif.err_overflow),   32'(vq[i].eovf));
            if (vq[i].dchk) begin
                chk($sformatf("v%0d.data", i), bif.out_data,     vq[i].ed);
                chk($sformatf("v%0d.src", i),  32'(bif.out_src), 32'(vq[i].es));
            end
        end

        // Overflow coinciding with err_clr keeps the flag set; a later clear drops it.
        step(1, 4'b0000, 32'h0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 4'b0001, 32'h40 + k, 0, 0);
        chk("sw.count_full", 32'(bif.count), 32'd4);
        step(0, 4'b0001, 32'h50, 0, 1);
        chk("sw.ovf_setwins", 32'(bif.err_overflow), 32'd1);
        chk("sw.head_kept",   bif.out_data, 32'h40);
        step(0, 4'b0000, 32'h0, 0, 1);
        chk("sw.ovf_cleared", 32'(bif.err_overflow), 32'd0);

        // Randomized traffic against the queue model
        model_cycle(1, 4'b0, 32'h0, 0, 0);
        step(1, 4'b0000, 32'h0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            logic        r, rdy, clr;
            logic [3:0]  en;
            logic [31:0] d;
            int          sel;
            sel = $urandom_range(0, 99);
            if (sel < 50)      en = 4'(1 << $urandom_range(0, 3));
            else if (sel < 75) en = 4'b0000;
            else               en = 4'($urandom_range(0, 15));
            d   = $urandom;
            rdy = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 8);
            r   = ($urandom_range(0, 199) == 0);
            model_cycle(r, en, d, rdy, clr);
            step(r, en, d, rdy, clr);
            chk($sformatf("r%0d.valid", c), 32'(bif.out_valid),      32'(mq_data.size() > 0));
            chk($sformatf("r%0d.count", c), 32'(bif.count),          32'(mq_data.size()));
            chk($sformatf("r%0d.econ", c),  32'(bif.err_contention), 32'(m_con));
            chk($sformatf("r%0d.eovf", c),  32'(bif.err_overflow),   32'(m_ovf));
            if (mq_data.size() > 0) begin
                chk($sformatf("r%0d.data", c), bif.out_data,     mq_data[0]);
                chk($sformatf("r%0d.src", c),  32'(bif.out_src), 32'(mq_src[0]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
